lfsr_checker: RTL



---
 rtl/lfsr_pkg.sv | 29 ++
 rtl/lfsr_predict.sv | 38 +++
 rtl/lfsr_checker.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/lfsr_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lfsr_pkg
// Purpose  : Shared constants and types for the BoW link LFSR pattern checker
//            and its prediction function: word width, feedback tap
//            positions, inversion threshold and checker state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package lfsr_pkg;

    localparam int N_DEF = 16;

    // Feedback taps, numbered with bit 1 as the MSB (generator bit order).
    localparam int TAP_A = 16;
    localparam int TAP_B = 15;
    localparam int TAP_C = 13;
    localparam int TAP_D = 4;

    // The shifted word is inverted when more than this many bits toggle.
    localparam int INV_THRESH = 7;

    typedef enum logic [1:0] {
        SEED   = 2'd0,
        ACQ    = 2'd1,
        LOCKED = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/lfsr_predict.sv
`default_nettype none
// ============================================================================
// Module   : lfsr_predict
// Purpose  : Combinational next-word prediction for the inversion-encoded
//            16-bit LFSR stream: shift in feedback, count toggles against the
//            previous word (last position excluded), invert on a high count.
// Ports    : i_prev [1:N] previous word as transmitted (bit 1 = MSB)
//            o_pred [1:N] predicted next word
// Revision : 1.0 - initial release
// ============================================================================
module lfsr_predict
    import lfsr_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic [1:N] i_prev,
    output logic [1:N] o_pred
);

    localparam int c_CW = $clog2(N) + 1;

    logic           w_fb;
    logic [1:N]     w_shift;
    logic [c_CW-1:0] w_toggles;

    always_comb begin
        w_fb      = i_prev[TAP_A] ^ i_prev[TAP_B] ^ i_prev[TAP_C] ^ i_prev[TAP_D];
        w_shift   = {w_fb, i_prev[1:N-1]};
        w_toggles = '0;
        // Position N is left out of the count to match the generator.
        for (int k = 1; k <= N - 1; k++) begin
            w_toggles = w_toggles + c_CW'(w_shift[k] ^ i_prev[k]);
        end
        o_pred = (w_toggles > c_CW'(INV_THRESH)) ? ~w_shift : w_shift;
    end

endmodule
`default_nettype wire

// File: rtl/lfsr_checker.sv
`default_nettype none
// ============================================================================
// Module   : lfsr_checker
// Purpose  : Receive-side checker for the BoW link LFSR test pattern. Seeds
//            from the first word, acquires lock after LOCK_COUNT consecutive
//            predicted matches, then free-runs and counts words and errors.
// Ports    : clk, reset          clock, synchronous active-high reset
//            rx_valid, rx_data   received word strobe and data (bit 1 = MSB)
//            clr_cnt             clear counters and first-error capture
//            locked              checker is in the LOCKED state
//            err_pulse           one-cycle strobe per mismatching locked word
//            word_cnt, err_cnt   saturating word / error counters (locked only)
//            first_err_bits      expected ^ received of first error since clear
// Revision : 1.0 - initial release
// ============================================================================
module lfsr_checker
    import lfsr_pkg::*;
#(
    parameter int N          = N_DEF,
    parameter int LOCK_COUNT = 8,
    parameter int LOSS_COUNT = 4,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rx_valid,
    input  logic [1:N]       rx_data,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] word_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [1:N]       first_err_bits
);

    state_t           r_state,     w_state_nxt;
    logic [1:N]       r_ref,       w_ref_nxt;
    logic [7:0]       r_match_run, w_match_run_nxt;
    logic [7:0]       r_miss_run,  w_miss_run_nxt;
    logic             r_err_pulse, w_err_pulse_nxt;
    logic [CNT_W-1:0] r_word_cnt,  w_word_cnt_nxt;
    logic [CNT_W-1:0] r_err_cnt,   w_err_cnt_nxt;
    logic [1:N]       r_first_err, w_first_err_nxt;

    logic [1:N]       w_pred;
    logic             w_match;

    lfsr_predict #(.N(N)) u_predict (
        .i_prev (r_ref),
        .o_pred (w_pred)
    );

    assign w_match = (rx_data == w_pred);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= SEED;
            r_ref       <= '0;
            r_match_run <= '0;
            r_miss_run  <= '0;
            r_err_pulse <= 1'b0;
            r_word_cnt  <= '0;
            r_err_cnt   <= '0;
            r_first_err <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_ref       <= w_ref_nxt;
            r_match_run <= w_match_run_nxt;
            r_miss_run  <= w_miss_run_nxt;
            r_err_pulse <= w_err_pulse_nxt;
            r_word_cnt  <= w_word_cnt_nxt;
            r_err_cnt   <= w_err_cnt_nxt;
            r_first_err <= w_first_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_ref_nxt       = r_ref;
        w_match_run_nxt = r_match_run;
        w_miss_run_nxt  = r_miss_run;
        w_err_pulse_nxt = 1'b0;
        w_word_cnt_nxt  = r_word_cnt;
        w_err_cnt_nxt   = r_err_cnt;
        w_first_err_nxt = r_first_err;

        if (rx_valid) begin
            case (r_state)
                SEED: begin
                    w_ref_nxt       = rx_data;
                    w_match_run_nxt = '0;
                    w_state_nxt     = ACQ;
                end
                ACQ: begin
                    // Re-seed from every received word so acquisition can
                    // start over from any point in the sequence.
                    w_ref_nxt = rx_data;
                    if (w_match) begin
                        if (r_match_run == 8'(LOCK_COUNT - 1)) begin
                            w_state_nxt     = LOCKED;
                            w_miss_run_nxt  = '0;
                            w_match_run_nxt = '0;
                        end else begin
                            w_match_run_nxt = r_match_run + 8'd1;
                        end
                    end else begin
                        w_match_run_nxt = '0;
                    end
                end
                LOCKED: begin
                    // Free-run on the prediction so a single corrupted word
                    // yields exactly one error instead of two.
                    w_ref_nxt = w_pred;
                    if (r_word_cnt != '1) begin
                        w_word_cnt_nxt = r_word_cnt + CNT_W'(1);
                    end
                    if (w_match) begin
                        w_miss_run_nxt = '0;
                    end else begin
                        w_err_pulse_nxt = 1'b1;
                        w_miss_run_nxt  = r_miss_run + 8'd1;
                        if (r_err_cnt != '1) begin
                            w_err_cnt_nxt = r_err_cnt + CNT_W'(1);
                        end
                        if (r_err_cnt == '0) begin
                            w_first_err_nxt = w_pred ^ rx_data;
                        end
                        if (r_miss_run + 8'd1 == 8'(LOSS_COUNT)) begin
                            w_state_nxt = SEED;
                        end
                    end
                end
                default: begin
                    w_state_nxt = SEED;
                end
            endcase
        end

        // Clear dominates any count or capture made in the same cycle.
        if (clr_cnt) begin
            w_word_cnt_nxt  = '0;
            w_err_cnt_nxt   = '0;
            w_first_err_nxt = '0;
        end
    end

    assign locked         = (r_state == LOCKED);
    assign err_pulse      = r_err_pulse;
    assign word_cnt       = r_word_cnt;
    assign err_cnt        = r_err_cnt;
    assign first_err_bits = r_first_err;

endmodule
`default_nettype wire
